// File: rtl/fhe_cmd_issuer_pkg.sv
// Shared FHE ALU definitions: command/status port structs, opcodes and issuer FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fhe_cmd_issuer_pkg;

    localparam int COMMAND_WIDTH        = 8;
    localparam int FSIZE                = 64;
    localparam int STATE_WIDTH          = 8;
    localparam int STACK_BUFFER_SIZE    = 32;
    localparam int GUARD_CYCLES_DEFAULT = 2;

    // FIFO entry layout: {command, data0, data1}
    localparam int CMD_ENTRY_WIDTH = COMMAND_WIDTH + 2 * FSIZE;

    localparam logic [COMMAND_WIDTH-1:0] COMMAND_RESET = 8'd111;
    localparam logic [STATE_WIDTH-1:0]   STATE_IDLE    = 8'd0;

    // Issuer FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic                     valid;
        logic [COMMAND_WIDTH-1:0] command;
        logic [FSIZE-1:0]         data0;
        logic [FSIZE-1:0]         data1;
    } CommandDataPort;

    typedef struct packed {
        logic [STATE_WIDTH-1:0] state0;
    } StatePort;

endpackage

// File: rtl/fhe_cmd_fifo.sv
// Synchronous command FIFO with occupancy output and single-cycle flush.
// Latency: a pushed entry is visible at head on the cycle after the push edge.
// Backpressure: none internally; caller must not push when full or pop when empty.
module fhe_cmd_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 136
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage write; payload needs no reset since level gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; flush beats push/pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Head reads straight from the storage flops so a pop edge can capture it.
    assign head  = mem[rd_ptr];
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

endmodule

// File: rtl/fhe_cmd_issuer.sv
// Queues host commands and issues them to the ALU one at a time with a guard/drain handshake.
// Latency: a push into an idle, empty issuer produces a valid pulse two cycles later; pulses are >= GUARD_CYCLES+2 apart.
// Backpressure: s_ready drops when the FIFO is full; COMMAND_RESET is always accepted and flushes the queue.
module fhe_cmd_issuer
    import fhe_cmd_issuer_pkg::*;
#(
    parameter int DEPTH        = STACK_BUFFER_SIZE,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [COMMAND_WIDTH-1:0]  s_command,
    input  logic [FSIZE-1:0]          s_data0,
    input  logic [FSIZE-1:0]          s_data1,
    output CommandDataPort            o_cmd,
    input  StatePort                  i_state,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic                      o_busy,
    output logic [31:0]               o_issued
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    logic [1:0]                 state;
    logic [GW-1:0]              guard_cnt;
    logic [CMD_ENTRY_WIDTH-1:0] head;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       is_reset;
    logic                       accept;
    logic                       accept_reset;
    logic                       push;
    logic                       pop;
    logic                       alu_idle;

    assign is_reset     = (s_command == COMMAND_RESET);
    assign s_ready      = is_reset || !fifo_full;
    assign accept       = s_valid && s_ready;
    assign accept_reset = accept && is_reset;
    assign push         = accept && !is_reset;
    assign alu_idle     = (i_state.state0 == STATE_IDLE);

    // Pop from IDLE, or straight out of DRAIN once the ALU reports idle so
    // back-to-back commands are spaced exactly ISSUE + GUARD + DRAIN cycles.
    // A RESET word in the same cycle pre-empts the queue.
    assign pop = !accept_reset && !fifo_empty &&
                 ((state == ST_IDLE) || ((state == ST_DRAIN) && alu_idle));

    assign o_busy = (state != ST_IDLE) || !fifo_empty;

    fhe_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_ENTRY_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data ({s_command, s_data0, s_data1}),
        .pop       (pop),
        .flush     (accept_reset),
        .head      (head),
        .level     (o_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Issue FSM: RESET bypass has top priority, then queue pops, then guard/drain sequencing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            guard_cnt <= '0;
            o_cmd     <= '0;
            o_issued  <= '0;
        end else begin
            o_cmd.valid <= 1'b0;
            if (accept_reset) begin
                state    <= ST_ISSUE;
                o_cmd    <= {1'b1, s_command, s_data0, s_data1};
                o_issued <= o_issued + 32'd1;
            end else if (pop) begin
                state    <= ST_ISSUE;
                o_cmd    <= {1'b1, head};
                o_issued <= o_issued + 32'd1;
            end else begin
                case (state)
                    ST_ISSUE: begin
                        guard_cnt <= '0;
                        state     <= (GUARD_CYCLES == 0) ? ST_DRAIN : ST_GUARD;
                    end
                    ST_GUARD: begin
                        if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
                            state <= ST_DRAIN;
                        end else begin
                            guard_cnt <= guard_cnt + GW'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (alu_idle) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fhe_cmd_issuer.sv
// Directed bench for fhe_cmd_issuer: cycle table for in-order issue plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_fhe_cmd_issuer;
    import fhe_cmd_issuer_pkg::*;

    logic           clk = 1'b0;
    logic           rstn;
    logic           s_valid;
    logic           s_ready;
    logic [7:0]     s_command;
    logic [63:0]    s_data0;
    logic [63:0]    s_data1;
    CommandDataPort o_cmd;
    StatePort       i_state;
    logic [5:0]     o_level;
    logic           o_busy;
    logic [31:0]    o_issued;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fhe_cmd_issuer #(.DEPTH(32), .GUARD_CYCLES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_command (s_command),
        .s_data0   (s_data0),
        .s_data1   (s_data1),
        .o_cmd     (o_cmd),
        .i_state   (i_state),
        .o_level   (o_level),
        .o_busy    (o_busy),
        .o_issued  (o_issued)
    );

    typedef struct {
        logic        sv;
        logic [7:0]  cmd;
        logic        e_rdy;
        logic        e_busy;
        logic [5:0]  e_lvl;
        logic        e_vld;
        logic [7:0]  e_cmd;
        logic [31:0] e_iss;
    } vec_t;

    vec_t vecs [15];

    logic        sb_on = 1'b0;
    logic [71:0] seen_q [$];

    // Capture every issued pulse while the ordering test is active.
    always @(negedge clk) begin
        if (sb_on && o_cmd.valid) seen_q.push_back({o_cmd.command, o_cmd.data0});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int budget);
        checks++;
        errors++;
        $display("FAIL %s: no event within %0d cycles, expected one", name, budget);
    endtask

    task automatic drive(input logic v, input logic [7:0] c);
        s_valid   = v;
        s_command = c;
        s_data0   = {8{c}};
        s_data1   = ~{8{c}};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        drive(1'b0, 8'd0);
        i_state.state0 = 8'd0;
        tick;
        tick;
        rstn = 1'b1;
    endtask

    initial begin
        int pulses;
        int n;
        logic all_ok;
        logic [7:0] first_cmd;

        // In-order issue of 66, 84, 41 with an always-idle ALU; one row per cycle.
        vecs[0]  = '{1'b1, 8'd66, 1'b1, 1'b0, 6'd0, 1'b0, 8'd0,  32'd0};
        vecs[1]  = '{1'b1, 8'd84, 1'b1, 1'b1, 6'd1, 1'b0, 8'd0,  32'd0};
        vecs[2]  = '{1'b1, 8'd41, 1'b1, 1'b1, 6'd1, 1'b1, 8'd66, 32'd1};
        vecs[3]  = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd2, 1'b0, 8'd66, 32'd1};
        vecs[4]  = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd2, 1'b0, 8'd66, 32'd1};
        vecs[5]  = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd2, 1'b0, 8'd66, 32'd1};
        vecs[6]  = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd1, 1'b1, 8'd84, 32'd2};
        vecs[7]  = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd1, 1'b0, 8'd84, 32'd2};
        vecs[8]  = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd1, 1'b0, 8'd84, 32'd2};
        vecs[9]  = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd1, 1'b0, 8'd84, 32'd2};
        vecs[10] = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd0, 1'b1, 8'd41, 32'd3};
        vecs[11] = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd0, 1'b0, 8'd41, 32'd3};
        vecs[12] = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd0, 1'b0, 8'd41, 32'd3};
        vecs[13] = '{1'b0, 8'd0,  1'b1, 1'b1, 6'd0, 1'b0, 8'd41, 32'd3};
        vecs[14] = '{1'b0, 8'd0,  1'b1, 1'b0, 6'd0, 1'b0, 8'd41, 32'd3};

        // Reset values
        rstn = 1'b1;
        drive(1'b0, 8'd0);
        i_state.state0 = 8'd0;
        #1 rstn = 1'b0;
        #1;
        chk("rst_level",  64'(o_level), 64'd0);
        chk("rst_valid",  64'(o_cmd.valid), 64'd0);
        chk("rst_cmd",    64'(o_cmd.command), 64'd0);
        chk("rst_data0",  o_cmd.data0, 64'd0);
        chk("rst_issued", 64'(o_issued), 64'd0);
        chk("rst_busy",   64'(o_busy), 64'd0);
        tick;
        tick;
        rstn = 1'b1;
        smp;
        chk("rst_ready", 64'(s_ready), 64'd1);
        tick;

        // Table: three commands, four-cycle spacing
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].sv, vecs[i].cmd);
            smp;
            chk($sformatf("v%0d_ready", i),  64'(s_ready),       64'(vecs[i].e_rdy));
            chk($sformatf("v%0d_busy", i),   64'(o_busy),        64'(vecs[i].e_busy));
            chk($sformatf("v%0d_level", i),  64'(o_level),       64'(vecs[i].e_lvl));
            chk($sformatf("v%0d_valid", i),  64'(o_cmd.valid),   64'(vecs[i].e_vld));
            chk($sformatf("v%0d_cmd", i),    64'(o_cmd.command), 64'(vecs[i].e_cmd));
            chk($sformatf("v%0d_issued", i), 64'(o_issued),      64'(vecs[i].e_iss));
            tick;
        end
        drive(1'b0, 8'd0);

        // ALU busy holds DRAIN: second command waits until state0 returns to idle
        do_reset;
        i_state.state0 = 8'd5;
        drive(1'b1, 8'd7);
        smp; tick;
        drive(1'b1, 8'd9);
        smp; tick;
        drive(1'b0, 8'd0);
        pulses = 0;
        all_ok = 1'b1;
        first_cmd = 8'd0;
        for (int c = 0; c < 16; c++) begin
            smp;
            if (o_cmd.valid) begin
                if (pulses == 0) first_cmd = o_cmd.command;
                pulses++;
            end
            if (!o_busy) all_ok = 1'b0;
            tick;
        end
        chk("hold_pulses", 64'(pulses), 64'd1);
        chk("hold_first",  64'(first_cmd), 64'd7);
        chk("hold_busy",   64'(all_ok), 64'd1);
        chk("hold_level",  64'(o_level), 64'd1);
        i_state.state0 = 8'd0;
        n = 0;
        for (n = 0; n < 6; n++) begin
            smp;
            if (o_cmd.valid) break;
            tick;
        end
        if (n == 6) timeout("hold_release", 6);
        else begin
            chk("hold_second_cmd", 64'(o_cmd.command), 64'd9);
            chk("hold_issued",     64'(o_issued), 64'd2);
        end

        // Fill to full with ALU busy, stall the next word, drain one entry
        do_reset;
        i_state.state0 = 8'd5;
        all_ok = 1'b1;
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, 8'(i + 1));
            smp;
            if (!s_ready) all_ok = 1'b0;
            tick;
        end
        chk("full_ready_during_fill", 64'(all_ok), 64'd1);
        drive(1'b1, 8'd34);
        smp;
        chk("full_level", 64'(o_level), 64'd32);
        chk("full_ready", 64'(s_ready), 64'd0);
        tick;
        for (int c = 0; c < 3; c++) begin
            smp;
            chk($sformatf("full_stall%0d_level", c), 64'(o_level), 64'd32);
            tick;
        end
        drive(1'b1, COMMAND_RESET);
        smp;
        chk("full_reset_ready", 64'(s_ready), 64'd1);
        drive(1'b1, 8'd34);
        tick;
        i_state.state0 = 8'd0;
        for (n = 0; n < 10; n++) begin
            smp;
            if (s_ready) break;
            tick;
        end
        if (n == 10) timeout("full_drain_ready", 10);
        else begin
            chk("full_drain_level", 64'(o_level), 64'd31);
            tick;
            drive(1'b0, 8'd0);
            smp;
            chk("full_refill_level", 64'(o_level), 64'd32);
        end

        // RESET while draining with 10 queued: flush and bypass
        do_reset;
        i_state.state0 = 8'd5;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 8'(50 + i));
            smp;
            tick;
        end
        drive(1'b0, 8'd0);
        smp;
        chk("rcmd_queued",  64'(o_level), 64'd10);
        chk("rcmd_issued0", 64'(o_issued), 64'd1);
        tick;
        drive(1'b1, COMMAND_RESET);
        smp;
        chk("rcmd_ready", 64'(s_ready), 64'd1);
        tick;
        drive(1'b0, 8'd0);
        smp;
        chk("rcmd_level",  64'(o_level), 64'd0);
        chk("rcmd_valid",  64'(o_cmd.valid), 64'd1);
        chk("rcmd_cmd",    64'(o_cmd.command), 64'd111);
        chk("rcmd_data0",  o_cmd.data0, 64'h6f6f_6f6f_6f6f_6f6f);
        chk("rcmd_issued", 64'(o_issued), 64'd2);
        i_state.state0 = 8'd0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            smp;
            if (o_cmd.valid) pulses++;
        end
        chk("rcmd_after_pulses", 64'(pulses), 64'd0);
        chk("rcmd_after_busy",   64'(o_busy), 64'd0);
        chk("rcmd_after_issued", 64'(o_issued), 64'd2);
        tick;

        // RESET during ISSUE: current pulse completes, RESET issues next, queue dropped
        do_reset;
        drive(1'b1, 8'd70);
        smp; tick;
        drive(1'b1, 8'd71);
        smp; tick;
        drive(1'b1, COMMAND_RESET);
        smp;
        chk("risu_cur_valid", 64'(o_cmd.valid), 64'd1);
        chk("risu_cur_cmd",   64'(o_cmd.command), 64'd70);
        tick;
        drive(1'b0, 8'd0);
        smp;
        chk("risu_valid",  64'(o_cmd.valid), 64'd1);
        chk("risu_cmd",    64'(o_cmd.command), 64'd111);
        chk("risu_level",  64'(o_level), 64'd0);
        chk("risu_issued", 64'(o_issued), 64'd2);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            smp;
            if (o_cmd.valid) pulses++;
        end
        chk("risu_after_pulses", 64'(pulses), 64'd0);
        tick;

        // Hardware reset mid-DRAIN with 5 queued
        do_reset;
        i_state.state0 = 8'd5;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(80 + i));
            smp;
            tick;
        end
        drive(1'b0, 8'd0);
        tick; tick;
        smp;
        chk("hrst_queued", 64'(o_level), 64'd5);
        #2 rstn = 1'b0;
        #1;
        chk("hrst_level",  64'(o_level), 64'd0);
        chk("hrst_valid",  64'(o_cmd.valid), 64'd0);
        chk("hrst_cmd",    64'(o_cmd.command), 64'd0);
        chk("hrst_data1",  o_cmd.data1, 64'd0);
        chk("hrst_issued", 64'(o_issued), 64'd0);
        chk("hrst_busy",   64'(o_busy), 64'd0);
        tick;
        rstn = 1'b1;
        i_state.state0 = 8'd0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            smp;
            if (o_cmd.valid) pulses++;
            tick;
        end
        chk("hrst_after_pulses", 64'(pulses), 64'd0);
        chk("hrst_after_ready",  64'(s_ready), 64'd1);

        // Push+pop at level 16, then 40 total pushes with wrap and order check
        do_reset;
        sb_on = 1'b1;
        i_state.state0 = 8'd5;
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 8'(i));
            smp;
            tick;
        end
        drive(1'b1, 8'd18);
        i_state.state0 = 8'd0;
        smp;
        chk("pp_level_before", 64'(o_level), 64'd16);
        tick;
        drive(1'b0, 8'd0);
        smp;
        chk("pp_level_after", 64'(o_level), 64'd16);
        chk("pp_valid",       64'(o_cmd.valid), 64'd1);
        tick;
        all_ok = 1'b1;
        for (int k = 19; k <= 40; k++) begin
            drive(1'b1, 8'(k));
            smp;
            if (!s_ready) all_ok = 1'b0;
            tick;
            drive(1'b0, 8'd0);
            smp;
            tick;
        end
        chk("wrap_ready", 64'(all_ok), 64'd1);
        for (n = 0; n < 400; n++) begin
            smp;
            if (!o_busy) break;
            tick;
        end
        if (n == 400) timeout("wrap_drain", 400);
        sb_on = 1'b0;
        chk("wrap_count", 64'(seen_q.size()), 64'd40);
        for (int i = 0; i < seen_q.size() && i < 40; i++) begin
            chk($sformatf("wrap%0d_cmd", i),   64'(seen_q[i][71:64]), 64'(i + 1));
            chk($sformatf("wrap%0d_data0", i), seen_q[i][63:0], {8{8'(i + 1)}});
        end
        chk("wrap_issued", 64'(o_issued), 64'd40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
